// File: rtl/token_load_ctrl.sv
// Token-table loader: at boot or on request, streams TOKEN_COUNT words from
// instruction memory into the decompressor token table while stalling the CPU.
module token_load_ctrl #(
    parameter int unsigned     WIDTH       = 32,
    parameter logic [WIDTH-1:0] TOKEN_BASE = '0,
    parameter int unsigned     TOKEN_COUNT = 102,
    parameter logic [WIDTH-1:0] PCADD      = WIDTH'(4)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] fetch_adr,
    output logic [WIDTH-1:0] imem_adr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             wme,
    output logic [WIDTH-1:0] wdata,
    output logic [9:0]       tok_idx,
    output logic             cpu_stall,
    output logic             done
);

    localparam int unsigned IDX_W    = 10;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOKEN_COUNT - 1);

    // S_BOOT is the pre-load state held during reset; it always launches a load.
    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   adr_q;

    // Token address advances by PCADD per entry, so no multiplier is needed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_BOOT;
            idx       <= '0;
            adr_q     <= TOKEN_BASE;
            wme       <= 1'b0;
            wdata     <= '0;
            tok_idx   <= '0;
            cpu_stall <= 1'b1;
            done      <= 1'b0;
        end else begin
            wme  <= 1'b0;
            done <= 1'b0;
            case (state)
                S_BOOT: begin
                    state <= S_FETCH;
                    idx   <= '0;
                    adr_q <= TOKEN_BASE;
                end
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        idx       <= '0;
                        adr_q     <= TOKEN_BASE;
                        cpu_stall <= 1'b1;
                    end
                end
                S_FETCH: begin
                    wdata   <= imem_rdata;
                    tok_idx <= idx;
                    wme     <= 1'b1;
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        adr_q <= adr_q + PCADD;
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    idx       <= '0;
                    cpu_stall <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

    // Only IDLE lets the decompressor fetch address through to memory.
    always_comb begin
        imem_adr = adr_q;
        if (state == S_IDLE) begin
            imem_adr = fetch_adr;
        end
    end

endmodule

// File: tb/tb_token_load_ctrl.sv
// Directed bench for token_load_ctrl: boot load, IDLE pass-through, reloads,
// mid-load reset, single-entry table and address wraparound.
module tb_token_load_ctrl;

    logic        clk;
    logic        start;
    logic [31:0] fetch_adr;
    int          checks;
    int          errors;

    // Instance A: TOKEN_COUNT=3 at 0x40
    logic        rst_a, wme_a, stall_a, done_a;
    logic [31:0] adr_a, rdata_a, wdata_a;
    logic [9:0]  idx_a;
    logic [31:0] mem_a [4];

    // Instance B: TOKEN_COUNT=1 at 0xFFFFFFFC
    logic        rst_b, wme_b, stall_b, done_b;
    logic [31:0] adr_b, rdata_b, wdata_b;
    logic [9:0]  idx_b;

    // Instance C: TOKEN_COUNT=2 at 0xFFFFFFFC (wraps to 0)
    logic        rst_c, wme_c, stall_c, done_c;
    logic [31:0] adr_c, rdata_c, wdata_c;
    logic [9:0]  idx_c;

    token_load_ctrl #(.WIDTH(32), .TOKEN_BASE(32'h40), .TOKEN_COUNT(3), .PCADD(32'd4)) dut_a (
        .clk(clk), .reset(rst_a), .start(start), .fetch_adr(fetch_adr),
        .imem_adr(adr_a), .imem_rdata(rdata_a), .wme(wme_a), .wdata(wdata_a),
        .tok_idx(idx_a), .cpu_stall(stall_a), .done(done_a));

    token_load_ctrl #(.WIDTH(32), .TOKEN_BASE(32'hFFFF_FFFC), .TOKEN_COUNT(1), .PCADD(32'd4)) dut_b (
        .clk(clk), .reset(rst_b), .start(1'b0), .fetch_adr(32'h0000_0100),
        .imem_adr(adr_b), .imem_rdata(rdata_b), .wme(wme_b), .wdata(wdata_b),
        .tok_idx(idx_b), .cpu_stall(stall_b), .done(done_b));

    token_load_ctrl #(.WIDTH(32), .TOKEN_BASE(32'hFFFF_FFFC), .TOKEN_COUNT(2), .PCADD(32'd4)) dut_c (
        .clk(clk), .reset(rst_c), .start(1'b0), .fetch_adr(32'h0000_0200),
        .imem_adr(adr_c), .imem_rdata(rdata_c), .wme(wme_c), .wdata(wdata_c),
        .tok_idx(idx_c), .cpu_stall(stall_c), .done(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rdata_a = 32'hDEAD_BEEF;
        if (adr_a[31:4] == 28'h4) rdata_a = mem_a[adr_a[3:2]];
    end

    always_comb begin
        rdata_b = 32'hBAD0_0000;
        if (adr_b == 32'hFFFF_FFFC) rdata_b = 32'h1111_2222;
    end

    always_comb begin
        rdata_c = 32'hBAD0_0001;
        if (adr_c == 32'hFFFF_FFFC) rdata_c = 32'hCAFE_0001;
        else if (adr_c == 32'h0000_0000) rdata_c = 32'hCAFE_0002;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one full 3-entry load on instance A, entered at cycle 1 (FETCH), ending at cycle 8 (IDLE).
    task automatic check_load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] words [3];
        logic        exp_wme, exp_done, exp_stall;
        logic [31:0] exp_adr;
        int          k;
        words[0] = w0; words[1] = w1; words[2] = w2;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc > 1) step();
            exp_wme   = (cyc == 2) || (cyc == 4) || (cyc == 6);
            exp_done  = (cyc == 7);
            exp_stall = (cyc != 8);
            checks++;
            if (wme_a !== exp_wme) begin
                errors++; $display("FAIL load_wme cyc=%0d got=%b exp=%b", cyc, wme_a, exp_wme);
            end
            checks++;
            if (done_a !== exp_done) begin
                errors++; $display("FAIL load_done cyc=%0d got=%b exp=%b", cyc, done_a, exp_done);
            end
            checks++;
            if (stall_a !== exp_stall) begin
                errors++; $display("FAIL load_stall cyc=%0d got=%b exp=%b", cyc, stall_a, exp_stall);
            end
            if (exp_wme) begin
                k = (cyc - 2) / 2;
                checks++;
                if (idx_a !== 10'(k)) begin
                    errors++; $display("FAIL load_tok_idx cyc=%0d got=%0d exp=%0d", cyc, idx_a, k);
                end
                checks++;
                if (wdata_a !== words[k]) begin
                    errors++; $display("FAIL load_wdata cyc=%0d got=%h exp=%h", cyc, wdata_a, words[k]);
                end
            end
            if (cyc <= 7) begin
                // FETCH drives 0x40+4*idx; WRITE/DONE keep the last FETCH address
                exp_adr = 32'h40 + 32'(4 * ((cyc - 1) / 2));
                if (cyc == 7) exp_adr = 32'h48;
                checks++;
                if (adr_a !== exp_adr) begin
                    errors++; $display("FAIL load_imem_adr cyc=%0d got=%h exp=%h", cyc, adr_a, exp_adr);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int n = 0; n < 2; n++) begin
            #1;
            checks++;
            if (wme_a !== 1'b0 || done_a !== 1'b0 || stall_a !== 1'b1) begin
                errors++; $display("FAIL reset_ctrl n=%0d got wme=%b done=%b stall=%b exp 0 0 1", n, wme_a, done_a, stall_a);
            end
            checks++;
            if (idx_a !== 10'd0 || wdata_a !== 32'h0) begin
                errors++; $display("FAIL reset_data n=%0d got idx=%0d wdata=%h exp 0 0", n, idx_a, wdata_a);
            end
            checks++;
            if (adr_a !== 32'h40) begin
                errors++; $display("FAIL reset_imem_adr n=%0d got=%h exp=00000040", n, adr_a);
            end
            step();
        end
    endtask

    task automatic test_boot();
        mem_a[0] = 32'hAAAA_0000; mem_a[1] = 32'hBBBB_1111; mem_a[2] = 32'hCCCC_2222; mem_a[3] = 32'h0;
        rst_a = 1'b1;
        #1;
        checks++;
        if (stall_a !== 1'b1 || wme_a !== 1'b0) begin
            errors++; $display("FAIL boot_cycle0 got stall=%b wme=%b exp 1 0", stall_a, wme_a);
        end
        step();
        check_load(32'hAAAA_0000, 32'hBBBB_1111, 32'hCCCC_2222);
    endtask

    task automatic test_idle_passthrough();
        fetch_adr = 32'h0000_1234;
        #1;
        checks++;
        if (adr_a !== 32'h0000_1234 || stall_a !== 1'b0 || wme_a !== 1'b0) begin
            errors++; $display("FAIL idle_pass got adr=%h stall=%b wme=%b exp 00001234 0 0", adr_a, stall_a, wme_a);
        end
        fetch_adr = 32'h0000_5678;
        #1;
        checks++;
        if (adr_a !== 32'h0000_5678) begin
            errors++; $display("FAIL idle_pass_change got=%h exp=00005678", adr_a);
        end
        step();
        checks++;
        if (stall_a !== 1'b0 || wme_a !== 1'b0 || idx_a !== 10'd2 || wdata_a !== 32'hCCCC_2222) begin
            errors++; $display("FAIL idle_hold got stall=%b wme=%b idx=%0d wdata=%h exp 0 0 2 cccc2222", stall_a, wme_a, idx_a, wdata_a);
        end
    endtask

    task automatic test_reload();
        mem_a[0] = 32'hDDDD_3333; mem_a[1] = 32'hEEEE_4444; mem_a[2] = 32'hFFFF_5555;
        start = 1'b1;
        step();
        start = 1'b0;
        check_load(32'hDDDD_3333, 32'hEEEE_4444, 32'hFFFF_5555);
    endtask

    task automatic test_start_held();
        start = 1'b1;
        step();
        check_load(32'hDDDD_3333, 32'hEEEE_4444, 32'hFFFF_5555);
        step();
        checks++;
        if (stall_a !== 1'b1 || adr_a !== 32'h40) begin
            errors++; $display("FAIL start_held_restart got stall=%b adr=%h exp 1 00000040", stall_a, adr_a);
        end
        start = 1'b0;
        check_load(32'hDDDD_3333, 32'hEEEE_4444, 32'hFFFF_5555);
    endtask

    task automatic test_reset_midload();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        checks++;
        if (wme_a !== 1'b1 || idx_a !== 10'd1) begin
            errors++; $display("FAIL midload_second_write got wme=%b idx=%0d exp 1 1", wme_a, idx_a);
        end
        #2;
        rst_a = 1'b0;
        #1;
        checks++;
        if (wme_a !== 1'b0 || idx_a !== 10'd0 || stall_a !== 1'b1 || adr_a !== 32'h40) begin
            errors++; $display("FAIL midload_abort got wme=%b idx=%0d stall=%b adr=%h exp 0 0 1 00000040", wme_a, idx_a, stall_a, adr_a);
        end
        step();
        rst_a = 1'b1;
        step();
        check_load(32'hDDDD_3333, 32'hEEEE_4444, 32'hFFFF_5555);
    endtask

    task automatic test_single_token();
        step();
        rst_b = 1'b1;
        step();
        checks++;
        if (adr_b !== 32'hFFFF_FFFC || wme_b !== 1'b0 || stall_b !== 1'b1) begin
            errors++; $display("FAIL single_fetch got adr=%h wme=%b stall=%b exp fffffffc 0 1", adr_b, wme_b, stall_b);
        end
        step();
        checks++;
        if (wme_b !== 1'b1 || idx_b !== 10'd0 || wdata_b !== 32'h1111_2222) begin
            errors++; $display("FAIL single_write got wme=%b idx=%0d wdata=%h exp 1 0 11112222", wme_b, idx_b, wdata_b);
        end
        step();
        checks++;
        if (done_b !== 1'b1 || wme_b !== 1'b0 || stall_b !== 1'b1) begin
            errors++; $display("FAIL single_done got done=%b wme=%b stall=%b exp 1 0 1", done_b, wme_b, stall_b);
        end
        step();
        checks++;
        if (done_b !== 1'b0 || stall_b !== 1'b0 || adr_b !== 32'h0000_0100) begin
            errors++; $display("FAIL single_idle got done=%b stall=%b adr=%h exp 0 0 00000100", done_b, stall_b, adr_b);
        end
    endtask

    task automatic test_wrap();
        step();
        rst_c = 1'b1;
        step();
        checks++;
        if (adr_c !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first_adr got=%h exp=fffffffc", adr_c);
        end
        step();
        checks++;
        if (wme_c !== 1'b1 || idx_c !== 10'd0 || wdata_c !== 32'hCAFE_0001) begin
            errors++; $display("FAIL wrap_first_write got wme=%b idx=%0d wdata=%h exp 1 0 cafe0001", wme_c, idx_c, wdata_c);
        end
        step();
        checks++;
        if (adr_c !== 32'h0000_0000 || wme_c !== 1'b0) begin
            errors++; $display("FAIL wrap_second_adr got adr=%h wme=%b exp 00000000 0", adr_c, wme_c);
        end
        step();
        checks++;
        if (wme_c !== 1'b1 || idx_c !== 10'd1 || wdata_c !== 32'hCAFE_0002) begin
            errors++; $display("FAIL wrap_second_write got wme=%b idx=%0d wdata=%h exp 1 1 cafe0002", wme_c, idx_c, wdata_c);
        end
        step();
        checks++;
        if (done_c !== 1'b1) begin
            errors++; $display("FAIL wrap_done got=%b exp=1", done_c);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        start     = 1'b0;
        fetch_adr = 32'h0;
        for (int i = 0; i < 4; i++) mem_a[i] = 32'h0;
        test_reset();
        test_boot();
        test_idle_passthrough();
        test_reload();
        test_start_held();
        test_reset_midload();
        test_single_token();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
